// File: rtl/match_run_pkg.sv
// Shared types and helpers for the consecutive-match run detector.
package match_run_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DETECT = 2'd2
  } state_e;

  localparam int MODE_TIMED = 0;
  localparam int MODE_ACK   = 1;

  function automatic int count_w(input int run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage

// File: rtl/match_run_detector_hold_timer.sv
// Loadable down-counter that sets how long the detect flag stays high in timed mode.
module hold_timer #(
  parameter int HOLD_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic zero
);

  localparam int TW = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Loading HOLD_CYC-1 makes the zero cycle the last of HOLD_CYC high cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = TW'(HOLD_CYC - 1);
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/match_run_detector.sv
// Counts consecutive equal X/Y samples and raises a registered detect flag after
// RUN_LEN of them, held for a fixed time or until acknowledged.
//
// Handshake: there is no valid/ready pair; EN qualifies a sample and is the only
// way an X/Y pair is consumed. ACK is a level sampled only while in DETECT (MODE 1).
module match_run_detector
  import match_run_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int RUN_LEN     = 8,
  parameter int FALLBACK_AT = 5,
  parameter int FALLBACK_TO = 1,
  parameter int HOLD_CYC    = 4,
  parameter int MODE        = 0,
  parameter int HIT_W       = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          EN,
  input  logic [WIDTH-1:0]              X,
  input  logic [WIDTH-1:0]              Y,
  input  logic                          ACK,
  output logic                          Z,
  output logic [count_w(RUN_LEN)-1:0]   COUNT,
  output logic                          BUSY,
  output logic [HIT_W-1:0]              HITS,
  output state_e                        dbg_state
);

  localparam int CW = count_w(RUN_LEN);
  localparam logic [CW-1:0] RUN_LEN_C = CW'(RUN_LEN);
  localparam logic [CW-1:0] FB_AT_C   = CW'(FALLBACK_AT);
  localparam logic [CW-1:0] FB_TO_C   = CW'(FALLBACK_TO);

  if (WIDTH < 1) begin : g_bad_width
    $error("match_run_detector: WIDTH must be at least 1");
  end
  if (RUN_LEN < 2) begin : g_bad_run_len
    $error("match_run_detector: RUN_LEN must be at least 2");
  end
  if ((FALLBACK_TO < 0) || (FALLBACK_TO >= FALLBACK_AT) || (FALLBACK_AT > RUN_LEN)) begin : g_bad_fallback
    $error("match_run_detector: need 0 <= FALLBACK_TO < FALLBACK_AT <= RUN_LEN");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("match_run_detector: HOLD_CYC must be at least 1");
  end
  if ((MODE != MODE_TIMED) && (MODE != MODE_ACK)) begin : g_bad_mode
    $error("match_run_detector: MODE must be 0 or 1");
  end
  if (HIT_W < 1) begin : g_bad_hit_w
    $error("match_run_detector: HIT_W must be at least 1");
  end

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     count_inc;
  logic [HIT_W-1:0]  hits_q, hits_d;
  logic              z_q, z_d;
  logic              match;
  logic              leave;
  logic              timer_load;
  logic              timer_tick;
  logic              timer_zero;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hits_d     = hits_q;
    z_d        = z_q;
    leave      = 1'b0;
    timer_load = 1'b0;
    timer_tick = 1'b0;
    match      = (X == Y);
    count_inc  = count_q + CW'(1);

    case (state_q)
      IDLE, RUN: begin
        if (EN) begin
          if (match) begin
            if (count_inc == RUN_LEN_C) begin
              state_d    = DETECT;
              z_d        = 1'b1;
              count_d    = RUN_LEN_C;
              timer_load = 1'b1;
              if (hits_q != '1) begin
                hits_d = hits_q + HIT_W'(1);
              end
            end else begin
              state_d = RUN;
              count_d = count_inc;
            end
          end else if (count_q >= FB_AT_C) begin
            // A long run survives a single glitch as a short partial run.
            count_d = FB_TO_C;
            state_d = (FALLBACK_TO > 0) ? RUN : IDLE;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end
      end
      DETECT: begin
        if (MODE == MODE_ACK) begin
          leave = ACK;
        end else begin
          leave      = timer_zero;
          timer_tick = ~timer_zero;
        end
        if (leave) begin
          state_d = IDLE;
          count_d = '0;
          z_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        z_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      count_q <= '0;
      hits_q  <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hits_q  <= hits_d;
      z_q     <= z_d;
    end
  end

  if (MODE == MODE_TIMED) begin : g_timer
    hold_timer #(
      .HOLD_CYC (HOLD_CYC)
    ) u_hold_timer (
      .clk  (CLK),
      .rst  (RST),
      .load (timer_load),
      .tick (timer_tick),
      .zero (timer_zero)
    );
  end else begin : g_no_timer
    assign timer_zero = 1'b0;
  end

  assign Z         = z_q;
  assign BUSY      = z_q;
  assign COUNT     = count_q;
  assign HITS      = hits_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_match_run_detector.sv
// Bench for match_run_detector: three configurations share one stimulus stream and
// are checked every cycle against a behavioural run model, plus directed literal checks.
module tb_match_run_detector;
  import match_run_pkg::*;

  // ---------------- clock / reset / inputs ----------------
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN  = 1'b0;
  logic       ACK = 1'b0;
  logic [3:0] X   = 4'h0;
  logic [3:0] Y   = 4'h0;

  always #5 CLK = ~CLK;

  // u0: defaults; u1: acknowledge mode; u2: short run, 1-cycle hold, 2-bit hits
  logic       z0, b0, z1, b1, z2, b2;
  logic [3:0] c0, c1;
  logic [1:0] c2;
  logic [7:0] h0, h1;
  logic [1:0] h2;
  state_e     s0, s1, s2;

  match_run_detector u0 (
    .CLK(CLK), .RST(RST), .EN(EN), .X(X), .Y(Y), .ACK(ACK),
    .Z(z0), .COUNT(c0), .BUSY(b0), .HITS(h0), .dbg_state(s0)
  );

  match_run_detector #(.MODE(1)) u1 (
    .CLK(CLK), .RST(RST), .EN(EN), .X(X), .Y(Y), .ACK(ACK),
    .Z(z1), .COUNT(c1), .BUSY(b1), .HITS(h1), .dbg_state(s1)
  );

  match_run_detector #(
    .RUN_LEN(3), .FALLBACK_AT(3), .FALLBACK_TO(0), .HOLD_CYC(1), .MODE(0), .HIT_W(2)
  ) u2 (
    .CLK(CLK), .RST(RST), .EN(EN), .X(X), .Y(Y), .ACK(ACK),
    .Z(z2), .COUNT(c2), .BUSY(b2), .HITS(h2), .dbg_state(s2)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int cfg_run(input int k);  return (k == 2) ? 3 : 8; endfunction
  function automatic int cfg_fa(input int k);   return (k == 2) ? 3 : 5; endfunction
  function automatic int cfg_ft(input int k);   return (k == 2) ? 0 : 1; endfunction
  function automatic int cfg_hold(input int k); return (k == 2) ? 1 : 4; endfunction
  function automatic int cfg_mode(input int k); return (k == 1) ? 1 : 0; endfunction
  function automatic int cfg_hmax(input int k); return (k == 2) ? 3 : 255; endfunction

  int m_cnt[3];
  int m_left[3];
  int m_hits[3];
  bit m_det[3];
  bit m_valid = 1'b0;

  // m_left counts the remaining high cycles of the detect flag
  always @(posedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      if (RST) begin
        m_cnt[k] = 0; m_left[k] = 0; m_hits[k] = 0; m_det[k] = 1'b0;
      end else if (m_det[k]) begin
        if (cfg_mode(k) == 0) begin
          m_left[k] = m_left[k] - 1;
          if (m_left[k] == 0) begin m_det[k] = 1'b0; m_cnt[k] = 0; end
        end else if (ACK) begin
          m_det[k] = 1'b0; m_cnt[k] = 0;
        end
      end else if (EN) begin
        if (X == Y) begin
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] == cfg_run(k)) begin
            m_det[k]  = 1'b1;
            m_left[k] = cfg_hold(k);
            if (m_hits[k] < cfg_hmax(k)) m_hits[k] = m_hits[k] + 1;
          end
        end else begin
          m_cnt[k] = (m_cnt[k] >= cfg_fa(k)) ? cfg_ft(k) : 0;
        end
      end
    end
    if (RST) m_valid = 1'b1;
  end

  task automatic cmp_inst(input int k, input int z, input int b, input int c,
                          input int h, input int s);
    int exp_s;
    exp_s = m_det[k] ? int'(DETECT) : ((m_cnt[k] == 0) ? int'(IDLE) : int'(RUN));
    chk($sformatf("u%0d.Z", k), z, int'(m_det[k]));
    chk($sformatf("u%0d.BUSY", k), b, int'(m_det[k]));
    chk($sformatf("u%0d.COUNT", k), c, m_cnt[k]);
    chk($sformatf("u%0d.HITS", k), h, m_hits[k]);
    chk($sformatf("u%0d.state", k), s, exp_s);
  endtask

  always @(negedge CLK) begin
    if (m_valid) begin
      cmp_inst(0, int'(z0), int'(b0), int'(c0), int'(h0), int'(s0));
      cmp_inst(1, int'(z1), int'(b1), int'(c1), int'(h1), int'(s1));
      cmp_inst(2, int'(z2), int'(b2), int'(c2), int'(h2), int'(s2));
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] xv, input logic [3:0] yv);
    EN = en; X = xv; Y = yv;
  endtask

  int u2_hits_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    RST = 1'b1;
    step();
    step();
    chk("reset.Z", int'(z0), 0);
    chk("reset.COUNT", int'(c0), 0);
    chk("reset.HITS", int'(h0), 0);

    // Continuous matches: full run, timed hold, back-to-back short runs on u2
    RST = 1'b0;
    drive(1'b1, 4'hA, 4'hA);
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e <= 7) begin
        chk("run.COUNT", int'(c0), e);
        chk("run.Z", int'(z0), 0);
      end else if (e <= 11) begin
        chk("hold.Z", int'(z0), 1);
        chk("hold.COUNT", int'(c0), 8);
      end else if (e == 12) begin
        chk("after_hold.Z", int'(z0), 0);
        chk("after_hold.COUNT", int'(c0), 0);
        chk("after_hold.HITS", int'(h0), 1);
      end
      if (e == 8) chk("ack_mode.Z", int'(z1), 1);
      if ((e % 4) == 3) chk("sat.HITS", int'(h2), u2_hits_exp[(e - 3) / 4]);
    end

    // Acknowledge mode: mismatches and no ACK keep detect
    drive(1'b1, 4'h3, 4'h2);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("ack_wait.Z", int'(z1), 1);
      chk("ack_wait.COUNT", int'(c1), 8);
    end
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    chk("ack.Z", int'(z1), 0);
    chk("ack.COUNT", int'(c1), 0);

    // Fallback after a long partial run
    RST = 1'b1;
    step();
    RST = 1'b0;
    drive(1'b1, 4'h5, 4'h5);
    repeat (6) step();
    chk("fb.COUNT6", int'(c0), 6);
    drive(1'b1, 4'h3, 4'h2);
    step();
    chk("fb.COUNT", int'(c0), 1);
    chk("fb.state", int'(s0), int'(RUN));
    drive(1'b1, 4'h5, 4'h5);
    repeat (6) step();
    chk("fb.Z_pre", int'(z0), 0);
    step();
    chk("fb.Z", int'(z0), 1);

    // Reset during detect, then mid-run, both with a matching sample present
    RST = 1'b1;
    step();
    chk("rst_det.Z", int'(z0), 0);
    chk("rst_det.COUNT", int'(c0), 0);
    chk("rst_det.HITS", int'(h0), 0);
    chk("rst_det.u1Z", int'(z1), 0);
    RST = 1'b0;
    repeat (5) step();
    chk("rst_run.pre", int'(c0), 5);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_run.COUNT", int'(c0), 0);

    // Short run mismatch clears the count
    repeat (4) step();
    chk("short.COUNT4", int'(c0), 4);
    drive(1'b1, 4'h3, 4'h2);
    step();
    chk("short.COUNT", int'(c0), 0);
    chk("short.state", int'(s0), int'(IDLE));

    // EN toggling: only enabled samples advance the run
    for (int e = 1; e <= 15; e++) begin
      drive((e % 2) == 1, 4'h7, 4'h7);
      step();
      if (e < 15) begin
        chk("en.COUNT", int'(c0), (e + 1) / 2);
        chk("en.Z", int'(z0), 0);
      end else begin
        chk("en.Z15", int'(z0), 1);
      end
    end

    // Randomised traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 299) == 0);
      EN  = ($urandom_range(0, 7) != 0);
      X   = 4'($urandom_range(0, 15));
      Y   = ($urandom_range(0, 3) != 0) ? X : 4'($urandom_range(0, 15));
      ACK = ($urandom_range(0, 5) == 0);
      step();
    end

    RST = 1'b0; EN = 1'b0; ACK = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
